// File: rtl/ysyx_25040129_axi_arb.sv
// ysyx_25040129_axi_arb: 2-to-1 AXI4 arbiter sharing io_master between the
// IFU (m0, read-only) and the LSU (m1, read/write).
// Reads are arbitrated per burst. Writes come only from m1. An m1 read is
// held back while any m1 write is pending, so it never overtakes that write.
// Optional macro AXI_ARB_FIXED_PRIO_EN: on a read tie the LSU always wins.
// Without the macro, ties are broken round-robin.
module ysyx_25040129_axi_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // m0: IFU read
    input  logic                  m0_arvalid,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [7:0]            m0_arlen,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    input  logic                  m0_rready,
    // m1: LSU read
    input  logic                  m1_arvalid,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [7:0]            m1_arlen,
    output logic                  m1_arready,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    input  logic                  m1_rready,
    // m1: LSU write
    input  logic                  m1_awvalid,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    output logic                  m1_awready,
    input  logic                  m1_wvalid,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_wready,
    output logic                  m1_bvalid,
    output logic [1:0]            m1_bresp,
    input  logic                  m1_bready,
    // downstream read
    output logic                  s_arvalid,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [7:0]            s_arlen,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    output logic                  s_rready,
    // downstream write
    output logic                  s_awvalid,
    output logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wlast,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    output logic                  s_bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;

    rd_state_t r_rd_state, w_rd_state_nxt;
    wr_state_t r_wr_state, w_wr_state_nxt;
    logic      r_grant, w_grant_nxt;          // 0 = m0, 1 = m1
    logic      r_aw_done, w_aw_done_nxt;
    logic      r_w_done, w_w_done_nxt;
    logic      r_en;                          // low during reset and the first cycle after
    logic      w_m0_elig, w_m1_elig, w_pick_m1;
    logic      w_ar_sel_valid, w_r_sel_ready;

    // An m1 read must wait while any part of an m1 write is pending or in flight
    assign w_m0_elig = m0_arvalid;
    assign w_m1_elig = m1_arvalid & (r_wr_state == W_IDLE) & ~m1_awvalid & ~m1_wvalid
                     & ~r_aw_done & ~r_w_done;

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign w_pick_m1 = w_m1_elig;
`else
    logic r_last_grant;                       // 1 = m1 was granted last
    assign w_pick_m1 = w_m1_elig & (~w_m0_elig | ~r_last_grant);

    // Remember the last read winner for round-robin tie breaking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_rd_state == R_IDLE && (w_m0_elig || w_m1_elig)) begin
            r_last_grant <= w_pick_m1;
        end
    end
`endif

    // Data paths are plain muxes or wires; only handshakes are gated
    assign s_araddr = r_grant ? m1_araddr : m0_araddr;
    assign s_arlen  = r_grant ? m1_arlen  : m0_arlen;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;
    assign s_awaddr = m1_awaddr;
    assign s_wdata  = m1_wdata;
    assign s_wstrb  = m1_wstrb;
    assign s_wlast  = 1'b1;
    assign m1_bresp = s_bresp;

    // State registers for both FSMs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
            r_grant    <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_grant    <= w_grant_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_en       <= 1'b1;
        end
    end

    // Read FSM: arbitrate in R_IDLE, forward address, then forward data until rlast
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_grant_nxt    = r_grant;
        s_arvalid      = 1'b0;
        m0_arready     = 1'b0;
        m1_arready     = 1'b0;
        m0_rvalid      = 1'b0;
        m1_rvalid      = 1'b0;
        s_rready       = 1'b0;
        w_ar_sel_valid = r_grant ? m1_arvalid : m0_arvalid;
        w_r_sel_ready  = r_grant ? m1_rready  : m0_rready;
        case (r_rd_state)
            R_IDLE: begin
                if (w_m0_elig || w_m1_elig) begin
                    w_grant_nxt    = w_pick_m1;
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid = w_ar_sel_valid;
                if (r_grant) m1_arready = s_arready;
                else         m0_arready = s_arready;
                if (w_ar_sel_valid && s_arready) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_rready = w_r_sel_ready;
                if (r_grant) m1_rvalid = s_rvalid;
                else         m0_rvalid = s_rvalid;
                if (s_rvalid && w_r_sel_ready && s_rlast) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Write FSM: accept AW and W in any order, then pass the B response back
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        s_awvalid      = 1'b0;
        m1_awready     = 1'b0;
        s_wvalid       = 1'b0;
        m1_wready      = 1'b0;
        m1_bvalid      = 1'b0;
        s_bready       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (r_en) begin
                    s_awvalid     = m1_awvalid & ~r_aw_done;
                    m1_awready    = s_awready  & ~r_aw_done;
                    s_wvalid      = m1_wvalid  & ~r_w_done;
                    m1_wready     = s_wready   & ~r_w_done;
                    w_aw_done_nxt = r_aw_done | (m1_awvalid & s_awready);
                    w_w_done_nxt  = r_w_done  | (m1_wvalid  & s_wready);
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        w_wr_state_nxt = W_RESP;
                        w_aw_done_nxt  = 1'b0;
                        w_w_done_nxt   = 1'b0;
                    end
                end
            end
            W_RESP: begin
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
                if (s_bvalid && m1_bready) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

endmodule
